// File: rtl/inst_rom_resp.sv
// Instruction-memory responder for the fetch stage: word-wide ROM/RAM with a
// program-load port, a fixed-latency read pipeline and misalign/range flags.
module inst_rom_resp #(
    parameter int DEPTH_LOG2 = 10,  // legal range 1..29
    parameter int LATENCY    = 1    // legal range 1..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] addr,
    output logic [31:0] inst_o,
    output logic        inst_valid,
    output logic [31:0] inst_addr_o,
    output logic        err_misalign,
    output logic        err_range,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic        misalign;
        logic        out_of_range;
    } stage_t;

    logic [31:0]           mem [DEPTH];
    stage_t                pipe [LATENCY];
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  req_misalign;
    logic                  req_oor;
    logic                  ld_oor;
    logic                  req_hit;
    logic                  unused_ld_bits;

    // Range is judged on the full address before the index is truncated,
    // so upper addresses never alias onto low memory.
    assign rd_idx       = addr[DEPTH_LOG2+1:2];
    assign req_misalign = addr[1:0] != 2'b00;
    assign req_oor      = addr[31:DEPTH_LOG2+2] != '0;
    assign req_hit      = ce && !req_misalign && !req_oor;

    assign wr_idx         = ld_addr[DEPTH_LOG2+1:2];
    assign ld_oor         = ld_addr[31:DEPTH_LOG2+2] != '0;
    assign unused_ld_bits = ^ld_addr[1:0];

    // NOTE: the array is deliberately left out of reset; only pipeline state
    // is cleared, so boot-loaded code survives a reset pulse.
    always_ff @(posedge clk) begin
        if (!rst && ld_we && !ld_oor) begin
            mem[wr_idx] <= ld_data;
        end
    end

    // NOTE: non-blocking assignments make the stage-1 read see the word as it
    // was before this edge's load, giving read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid        <= ce;
            pipe[0].addr         <= ce ? addr : 32'h0;
            pipe[0].data         <= req_hit ? mem[rd_idx] : 32'h0;
            pipe[0].misalign     <= ce && req_misalign;
            pipe[0].out_of_range <= ce && req_oor;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Bubbles travel as all-zero stages, so outputs are zeroed rather than held.
    assign inst_valid   = pipe[LATENCY-1].valid;
    assign inst_o       = pipe[LATENCY-1].data;
    assign inst_addr_o  = pipe[LATENCY-1].addr;
    assign err_misalign = pipe[LATENCY-1].misalign;
    assign err_range    = pipe[LATENCY-1].out_of_range;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Scoreboard bench: two responders (LATENCY 1 and 3) share stimulus; a word
// array model predicts each response, and per-DUT monitors check every cycle.
module tb_inst_rom_resp;

    localparam int DL = 10;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [31:0] addr;
        logic        mis;
        logic        oor;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, ce, ld_we;
    logic [31:0] addr, ld_addr, ld_data;

    logic [31:0] inst1, iaddr1, inst3, iaddr3;
    logic        val1, mis1, oor1, val3, mis3, oor3;

    int          edge_cnt = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] mem_m [1 << DL];

    inst_rom_resp #(.DEPTH_LOG2(DL), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr),
        .inst_o(inst1), .inst_valid(val1), .inst_addr_o(iaddr1),
        .err_misalign(mis1), .err_range(oor1),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    inst_rom_resp #(.DEPTH_LOG2(DL), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr),
        .inst_o(inst3), .inst_valid(val3), .inst_addr_o(iaddr3),
        .err_misalign(mis3), .err_range(oor3),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_cnt, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >> (DL + 2)) == 0;
    endfunction

    function automatic exp_t predict(input logic [31:0] a, input int due);
        exp_t e;
        e.due  = due;
        e.addr = a;
        e.mis  = (a % 4) != 0;
        e.oor  = !in_range(a);
        e.data = (e.mis || e.oor) ? 32'h0 : mem_m[a / 4];
        return e;
    endfunction

    // One clock of stimulus; the model consumes it exactly as the spec's rules say.
    task automatic step(input bit r, input bit c, input logic [31:0] a,
                        input bit we, input logic [31:0] la, input logic [31:0] ld);
        rst = r; ce = c; addr = a; ld_we = we; ld_addr = la; ld_data = ld;
        if (!r && c) begin
            q1.push_back(predict(a, edge_cnt + 1));
            q3.push_back(predict(a, edge_cnt + 3));
        end
        if (!r && we && in_range(la)) mem_m[(la % (4 << DL)) / 4] = ld;
        @(posedge clk);
        #1;
        if (r) begin
            q1.delete();
            q3.delete();
        end
    endtask

    task automatic check_resp(input string nm, input logic v, input logic [31:0] d,
                              input logic [31:0] a, input logic m, input logic o,
                              input bit have, input exp_t e);
        check({nm, " valid"}, 32'(v), 32'(have));
        if (have) begin
            check({nm, " data"}, d, e.data);
            check({nm, " addr"}, a, e.addr);
            check({nm, " misalign"}, 32'(m), 32'(e.mis));
            check({nm, " range"}, 32'(o), 32'(e.oor));
        end else begin
            check({nm, " idle outputs"}, d | a | 32'(m) | 32'(o), 32'h0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (edge_cnt > 0) begin
            have = q1.size() > 0 && q1[0].due <= edge_cnt;
            if (have) e = q1.pop_front();
            check_resp("lat1", val1, inst1, iaddr1, mis1, oor1, have, e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (edge_cnt > 0) begin
            have = q3.size() > 0 && q3[0].due <= edge_cnt;
            if (have) e = q3.pop_front();
            check_resp("lat3", val3, inst3, iaddr3, mis3, oor3, have, e);
        end
    end

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        logic [31:0] a;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2, 3, 4, 5: a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            6:       a = {20'h0, 12'($urandom_range(0, 4095))} | 32'h1;
            7:       a = $urandom | 32'h0000_1000;
            8: begin
                case ($urandom_range(0, 3))
                    0: a = 32'h0000_0FFC;
                    1: a = 32'h0000_1000;
                    2: a = 32'h8000_0000;
                    default: a = 32'h0000_0FFF;
                endcase
            end
            default: a = $urandom;
        endcase
        return a;
    endfunction

    initial begin
        // Reset/idle: outputs must stay zero, including after rst falls.
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 32'h0, 32'h0);

        // Preload the whole array so every later fetch has a defined word.
        for (int i = 0; i < (1 << DL); i++) step(0, 0, 32'h0, 1, 32'(i * 4) | 32'($urandom_range(0, 3)), $urandom);
        step(0, 0, 32'h0, 1, 32'h0, 32'h1111_1111);
        step(0, 0, 32'h0, 1, 32'h4, 32'h2222_2222);
        step(0, 0, 32'h0, 1, 32'h8, 32'h3333_3333);
        step(0, 0, 32'h0, 1, 32'hC, 32'h4444_4444);
        step(0, 0, 32'h0, 1, 32'h0000_2000, 32'hDEAD_0000);  // dropped: out of range

        // Streaming, then bubble pattern.
        for (int i = 0; i < 4; i++) step(0, 1, 32'(i * 4), 0, 32'h0, 32'h0);
        step(0, 1, 32'h0, 0, 32'h0, 32'h0);
        step(0, 0, 32'h8, 0, 32'h0, 32'h0);
        step(0, 1, 32'h4, 0, 32'h0, 32'h0);

        // Error flags and no aliasing of 0x1000 onto word 0.
        step(0, 1, 32'h6, 0, 32'h0, 32'h0);
        step(0, 1, 32'h1000, 0, 32'h0, 32'h0);
        step(0, 1, 32'h1002, 0, 32'h0, 32'h0);

        // Same-cycle load and fetch of word 2: old word first, new word after.
        step(0, 0, 32'h0, 1, 32'h8, 32'hAAAA_0000);
        step(0, 1, 32'h8, 1, 32'h8, 32'hBBBB_0000);
        step(0, 1, 32'h8, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 32'h0, 32'h0);

        // Reset mid-flight: in-flight fetches vanish; loads and fetches under rst ignored.
        step(0, 1, 32'h0, 0, 32'h0, 32'h0);
        step(0, 1, 32'h4, 0, 32'h0, 32'h0);
        step(1, 1, 32'h8, 1, 32'h0, 32'hDEAD_BEEF);
        step(1, 0, 32'h0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 32'h0, 32'h0);
        step(0, 1, 32'h0, 0, 32'h0, 32'h0);

        // Randomized traffic with overlapping loads and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          we;
            logic [31:0] la;
            r  = $urandom_range(0, 149) == 0;
            we = $urandom_range(0, 3) == 0;
            la = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_1000)
                                             : 32'($urandom_range(0, 4095));
            step(r, 1'($urandom_range(0, 4) != 0), rand_addr(), we, la, $urandom);
        end

        for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 0, 32'h0, 32'h0);
        check("lat1 scoreboard drained", 32'(q1.size()), 32'h0);
        check("lat3 scoreboard drained", 32'(q3.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
